// File: rtl/gr_wb_arbiter.sv
// gr_wb_arbiter: register-file writeback arbiter for one ALU port and one
// long-latency port. Long results wait in a 2-entry FIFO, and the ALU has
// priority. A starvation counter raises alu_hold so the pipeline can leave a
// writeback bubble. A busy-bit scoreboard tracks outstanding long-latency
// destinations.
//
// Long-result handshake: a result transfers on a rising edge where
// lng_valid && lng_ready. The source holds lng_waddr/lng_wdata stable until
// that edge. lng_ready depends only on reset and FIFO occupancy, never on
// lng_valid or on a same-cycle pop.
module gr_wb_arbiter #(
  parameter int STARVE_LIM = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_we,
  input  logic [4:0]  alu_waddr,
  input  logic [31:0] alu_wdata,
  input  logic        lng_valid,
  output logic        lng_ready,
  input  logic [4:0]  lng_waddr,
  input  logic [31:0] lng_wdata,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        alu_hold,
  input  logic        sb_set_valid,
  input  logic [4:0]  sb_set_addr,
  input  logic [4:0]  sb_raddr1,
  input  logic [4:0]  sb_raddr2,
  input  logic [4:0]  sb_raddr3,
  output logic        sb_busy1,
  output logic        sb_busy2,
  output logic        sb_busy3,
  output logic        sb_err
);

  localparam int CW = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIM);

  // FIFO storage and pointers
  logic [4:0]    fifo_addr [2];
  logic [31:0]   fifo_data [2];
  logic          rd_ptr;
  logic          wr_ptr;
  logic [1:0]    count;

  logic          alu_win;
  logic          push;
  logic          pop;
  logic          rf_from_lng;
  logic [CW-1:0] starve;

  logic [31:1]   busy;
  logic [31:0]   busy_vec;
  logic [31:0]   busy_nxt;
  logic          sb_set;
  logic          sb_clr;

  assign lng_ready = !rst && (count != 2'd2);
  assign alu_win   = alu_we && (alu_waddr != 5'd0);
  // Results for r0 are accepted off the port but never queued.
  assign push      = lng_valid && lng_ready && (lng_waddr != 5'd0);
  // Pop is based on the pre-edge count, so a push into an empty FIFO is not
  // popped on the same edge.
  assign pop       = !alu_win && (count != 2'd0);
  assign alu_hold  = (starve == LIM);

  // FIFO push/pop and occupancy tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        fifo_addr[wr_ptr] <= lng_waddr;
        fifo_data[wr_ptr] <= lng_wdata;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Registered writeback port: ALU first, then FIFO head, else idle
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we       <= 1'b0;
      rf_waddr    <= 5'd0;
      rf_wdata    <= 32'd0;
      rf_from_lng <= 1'b0;
    end else if (alu_win) begin
      rf_we       <= 1'b1;
      rf_waddr    <= alu_waddr;
      rf_wdata    <= alu_wdata;
      rf_from_lng <= 1'b0;
    end else if (pop) begin
      rf_we       <= 1'b1;
      rf_waddr    <= fifo_addr[rd_ptr];
      rf_wdata    <= fifo_data[rd_ptr];
      rf_from_lng <= 1'b1;
    end else begin
      rf_we       <= 1'b0;
      rf_from_lng <= 1'b0;
    end
  end

  // Starvation counter: counts ALU wins over a waiting head, saturating
  always_ff @(posedge clk) begin
    if (rst || (count == 2'd0) || pop) begin
      starve <= '0;
    end else if (alu_win && (starve != LIM)) begin
      starve <= starve + 1'b1;
    end
  end

  // Busy bits drop on the edge that commits the long write, so a reader sees
  // the new register value in the same cycle busy reads 0.
  assign sb_set   = sb_set_valid && (sb_set_addr != 5'd0);
  assign sb_clr   = rf_we && rf_from_lng;
  assign busy_vec = {busy, 1'b0};

  // Next busy vector: clear applied first so a same-edge set wins
  always_comb begin
    busy_nxt = busy_vec;
    if (sb_clr) begin
      busy_nxt[rf_waddr] = 1'b0;
    end
    if (sb_set) begin
      busy_nxt[sb_set_addr] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  // Scoreboard state and sticky double-set error
  always_ff @(posedge clk) begin
    if (rst) begin
      busy   <= '0;
      sb_err <= 1'b0;
    end else begin
      busy <= busy_nxt[31:1];
      if (sb_set && busy_vec[sb_set_addr] &&
          !(sb_clr && (rf_waddr == sb_set_addr))) begin
        sb_err <= 1'b1;
      end
    end
  end

  assign sb_busy1 = busy_vec[sb_raddr1];
  assign sb_busy2 = busy_vec[sb_raddr2];
  assign sb_busy3 = busy_vec[sb_raddr3];

endmodule

// File: tb/tb_gr_wb_arbiter.sv
// tb_gr_wb_arbiter: directed stimulus for gr_wb_arbiter. A queue-based model
// predicts every output each cycle, and hand-computed literals pin the model
// at the key points.
module tb_gr_wb_arbiter;

  localparam int LIM = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        alu_we = 0;
  logic [4:0]  alu_waddr = 0;
  logic [31:0] alu_wdata = 0;
  logic        lng_valid = 0;
  logic        lng_ready;
  logic [4:0]  lng_waddr = 0;
  logic [31:0] lng_wdata = 0;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        alu_hold;
  logic        sb_set_valid = 0;
  logic [4:0]  sb_set_addr = 0;
  logic [4:0]  sb_raddr1 = 0, sb_raddr2 = 0, sb_raddr3 = 0;
  logic        sb_busy1, sb_busy2, sb_busy3;
  logic        sb_err;

  gr_wb_arbiter #(.STARVE_LIM(LIM)) dut (
    .clk(clk), .rst(rst),
    .alu_we(alu_we), .alu_waddr(alu_waddr), .alu_wdata(alu_wdata),
    .lng_valid(lng_valid), .lng_ready(lng_ready),
    .lng_waddr(lng_waddr), .lng_wdata(lng_wdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .alu_hold(alu_hold),
    .sb_set_valid(sb_set_valid), .sb_set_addr(sb_set_addr),
    .sb_raddr1(sb_raddr1), .sb_raddr2(sb_raddr2), .sb_raddr3(sb_raddr3),
    .sb_busy1(sb_busy1), .sb_busy2(sb_busy2), .sb_busy3(sb_busy3),
    .sb_err(sb_err)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t        exp_q[$];       // long results waiting for the register file
  bit          m_busy[32];
  bit          m_err = 0;
  int          m_cnt = 0;
  bit          e_we = 0;
  logic [4:0]  e_addr = 0;
  logic [31:0] e_data = 0;
  bit          e_lng = 0;
  bit          model_live = 0;

  // Model advances on each edge from the inputs the DUT also sees
  always @(posedge clk) begin : model
    int         sz;
    bit         alu, acc, pp, clr, st;
    logic [4:0] ca;
    ent_t       h;
    model_live = 1;
    if (rst) begin
      exp_q.delete();
      foreach (m_busy[i]) m_busy[i] = 0;
      m_err = 0; m_cnt = 0;
      e_we = 0; e_addr = 0; e_data = 0; e_lng = 0;
    end else begin
      sz  = exp_q.size();
      alu = alu_we && (alu_waddr != 0);
      acc = lng_valid && (sz < 2);
      pp  = !alu && (sz > 0);
      clr = e_we && e_lng;
      ca  = e_addr;
      st  = sb_set_valid && (sb_set_addr != 0);
      if (st && m_busy[sb_set_addr] && !(clr && ca == sb_set_addr)) m_err = 1;
      if (clr) m_busy[ca] = 0;
      if (st) m_busy[sb_set_addr] = 1;
      if (sz == 0 || pp) m_cnt = 0;
      else if (m_cnt < LIM) m_cnt++;
      if (alu) begin
        e_we = 1; e_addr = alu_waddr; e_data = alu_wdata; e_lng = 0;
      end else if (pp) begin
        h = exp_q.pop_front();
        e_we = 1; e_addr = h.a; e_data = h.d; e_lng = 1;
      end else begin
        e_we = 0; e_lng = 0;
      end
      if (acc && lng_waddr != 0) begin
        h.a = lng_waddr; h.d = lng_wdata;
        exp_q.push_back(h);
      end
    end
  end

  // Per-cycle compare, mid-cycle when inputs and outputs are settled
  always @(negedge clk) begin
    if (model_live) begin
      chk("rf_we", {31'd0, rf_we}, {31'd0, e_we});
      chk("rf_waddr", {27'd0, rf_waddr}, {27'd0, e_addr});
      chk("rf_wdata", rf_wdata, e_data);
      chk("lng_ready", {31'd0, lng_ready}, {31'd0, (!rst && exp_q.size() < 2)});
      chk("alu_hold", {31'd0, alu_hold}, {31'd0, (m_cnt == LIM)});
      chk("sb_busy1", {31'd0, sb_busy1}, {31'd0, m_busy[sb_raddr1]});
      chk("sb_busy2", {31'd0, sb_busy2}, {31'd0, m_busy[sb_raddr2]});
      chk("sb_busy3", {31'd0, sb_busy3}, {31'd0, m_busy[sb_raddr3]});
      chk("sb_err", {31'd0, sb_err}, {31'd0, m_err});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_we = 0; lng_valid = 0; sb_set_valid = 0;
  endtask

  task automatic drive_alu(input logic we, input logic [4:0] a, input logic [31:0] d);
    alu_we = we; alu_waddr = a; alu_wdata = d;
  endtask

  task automatic drive_lng(input logic v, input logic [4:0] a, input logic [31:0] d);
    lng_valid = v; lng_waddr = a; lng_wdata = d;
  endtask

  task automatic drive_set(input logic v, input logic [4:0] a);
    sb_set_valid = v; sb_set_addr = a;
  endtask

  // Watchdog: the directed sequence is short; anything this long is a hang
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1);
  end

  // ---------------- directed stimulus ----------------
  initial begin
    // Reset
    rst = 1;
    tick(); tick();
    chk("lit_reset_rf_we", {31'd0, rf_we}, 32'd0);
    chk("lit_reset_rf_waddr", {27'd0, rf_waddr}, 32'd0);
    chk("lit_reset_ready", {31'd0, lng_ready}, 32'd0);
    rst = 0;
    #1;
    chk("lit_ready_after_rst", {31'd0, lng_ready}, 32'd1);

    // ALU only
    drive_alu(1, 5'd5, 32'h11);
    tick();
    chk("lit_alu_we", {31'd0, rf_we}, 32'd1);
    chk("lit_alu_addr", {27'd0, rf_waddr}, 32'd5);
    chk("lit_alu_data", rf_wdata, 32'h11);
    drive_alu(1, 5'd0, 32'h22);
    tick();
    chk("lit_r0_we", {31'd0, rf_we}, 32'd0);
    chk("lit_r0_keep_addr", {27'd0, rf_waddr}, 32'd5);
    chk("lit_r0_keep_data", rf_wdata, 32'h11);

    // Long path with scoreboard on r7
    idle();
    sb_raddr1 = 5'd7; sb_raddr3 = 5'd0;
    drive_set(1, 5'd7);
    tick();
    chk("lit_r7_busy", {31'd0, sb_busy1}, 32'd1);
    chk("lit_r0_never_busy", {31'd0, sb_busy3}, 32'd0);
    drive_set(0, 5'd0);
    drive_lng(1, 5'd7, 32'hABCD);
    tick();
    chk("lit_push_no_same_pop", {31'd0, rf_we}, 32'd0);
    drive_lng(0, 5'd0, 32'd0);
    tick();
    chk("lit_lng_we", {31'd0, rf_we}, 32'd1);
    chk("lit_lng_addr", {27'd0, rf_waddr}, 32'd7);
    chk("lit_lng_data", rf_wdata, 32'hABCD);
    chk("lit_r7_busy_in_we", {31'd0, sb_busy1}, 32'd1);
    tick();
    chk("lit_r7_cleared", {31'd0, sb_busy1}, 32'd0);
    chk("lit_lng_we_off", {31'd0, rf_we}, 32'd0);

    // FIFO full under continuous ALU writes, then starvation release
    drive_alu(1, 5'd3, 32'h301);
    drive_lng(1, 5'd10, 32'hA);
    tick();                                        // r10 accepted
    chk("lit_ready_cnt1", {31'd0, lng_ready}, 32'd1);
    drive_alu(1, 5'd3, 32'h302);
    drive_lng(1, 5'd11, 32'hB);
    tick();                                        // r11 accepted, blocked 1
    chk("lit_full_ready", {31'd0, lng_ready}, 32'd0);
    chk("lit_hold_b1", {31'd0, alu_hold}, 32'd0);
    drive_alu(1, 5'd3, 32'h303);
    drive_lng(1, 5'd12, 32'hC);
    tick();                                        // r12 stalled, blocked 2
    chk("lit_hold_b2", {31'd0, alu_hold}, 32'd0);
    drive_alu(1, 5'd3, 32'h304);
    tick();                                        // blocked 3
    chk("lit_hold_b3", {31'd0, alu_hold}, 32'd1);
    chk("lit_still_full", {31'd0, lng_ready}, 32'd0);
    drive_alu(1, 5'd3, 32'h305);
    tick();                                        // ALU still wins under hold
    chk("lit_alu_wins_hold", rf_wdata, 32'h305);
    chk("lit_hold_sat", {31'd0, alu_hold}, 32'd1);
    drive_alu(0, 5'd3, 32'd0);
    tick();                                        // pop r10
    chk("lit_drain1_addr", {27'd0, rf_waddr}, 32'd10);
    chk("lit_drain1_data", rf_wdata, 32'hA);
    chk("lit_hold_released", {31'd0, alu_hold}, 32'd0);
    tick();                                        // pop r11, push r12
    chk("lit_drain2_data", rf_wdata, 32'hB);
    drive_lng(0, 5'd0, 32'd0);
    tick();                                        // pop r12
    chk("lit_drain3_data", rf_wdata, 32'hC);
    tick();

    // Same-edge set/clear of r9, then an illegal double set
    idle();
    sb_raddr1 = 5'd9;
    drive_set(1, 5'd9);
    tick();
    drive_set(0, 5'd0);
    drive_lng(1, 5'd9, 32'h99);
    tick();
    drive_lng(0, 5'd0, 32'd0);
    tick();                                        // rf_we from long r9
    drive_set(1, 5'd9);
    tick();                                        // set and clear together
    chk("lit_r9_set_wins", {31'd0, sb_busy1}, 32'd1);
    chk("lit_r9_no_err", {31'd0, sb_err}, 32'd0);
    tick();                                        // set while busy
    chk("lit_r9_err", {31'd0, sb_err}, 32'd1);
    drive_set(0, 5'd0);
    tick(); tick();
    chk("lit_err_sticky", {31'd0, sb_err}, 32'd1);

    // Reset with two queued entries
    sb_raddr2 = 5'd4;
    drive_set(1, 5'd4);
    drive_alu(1, 5'd2, 32'h201);
    drive_lng(1, 5'd20, 32'h20);
    tick();
    drive_set(0, 5'd0);
    drive_lng(1, 5'd21, 32'h21);
    tick();
    drive_lng(0, 5'd0, 32'd0);
    chk("lit_two_queued", {31'd0, lng_ready}, 32'd0);
    idle();
    rst = 1;
    #1;
    chk("lit_ready_in_rst", {31'd0, lng_ready}, 32'd0);
    tick();
    chk("lit_rst_rf_we", {31'd0, rf_we}, 32'd0);
    chk("lit_rst_busy4", {31'd0, sb_busy2}, 32'd0);
    chk("lit_rst_busy9", {31'd0, sb_busy1}, 32'd0);
    chk("lit_rst_err", {31'd0, sb_err}, 32'd0);
    tick();
    rst = 0;
    #1;
    chk("lit_ready_post_rst", {31'd0, lng_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("lit_no_stale_we", {31'd0, rf_we}, 32'd0);
    end

    // Ignored r0 long result must not enqueue
    drive_lng(1, 5'd0, 32'hDEAD);
    tick();
    drive_lng(0, 5'd0, 32'd0);
    tick();
    chk("lit_r0_lng_dropped", {31'd0, rf_we}, 32'd0);
    tick();

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
